// File: rtl/core_pkg.sv
// Shared core types: MDU opcodes, MDU states, MDU constants.
// Imported by the EX-stage multiply/divide unit.
package core_pkg;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'd0,
    MDU_MULH   = 3'd1,
    MDU_MULHSU = 3'd2,
    MDU_MULHU  = 3'd3,
    MDU_DIV    = 3'd4,
    MDU_DIVU   = 3'd5,
    MDU_REM    = 3'd6,
    MDU_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_FIX,
    MDU_DONE
  } mdu_state_e;

  localparam logic [31:0] MDU_DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] MDU_OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/core_ex_mdu_addsub.sv
// Shared add/sub for the MDU: y = a + b or a - b, with carry out.
// Ports: a, b, sub in; y, co out (co=1 on subtract means no borrow).
module core_ex_mdu_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] y,
  output logic         co
);

  logic [W-1:0] bx;

  assign bx      = sub ? ~b : b;
  assign {co, y} = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};

endmodule

// File: rtl/core_ex_mdu.sv
// Iterative RV32M multiply/divide unit beside the EX ALU.
// Ports: clk, rest, op_wait_handle, op_start, op, in1, in2, flush; op_ready, out, busy.
module core_ex_mdu
  import core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rest,
  input  logic            op_wait_handle,
  input  logic            op_start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            flush,
  output logic            op_ready,
  output logic [XLEN-1:0] out,
  output logic            busy
);

  mdu_state_e      state, state_d;
  logic [CNT_W-1:0] cnt;
  mdu_op_e         op_q, op_e;
  logic [XLEN-1:0] hi, lo, bq;
  logic            neg_q, negr_q;

  logic            s1, s2, neg1, neg2;
  logic [XLEN-1:0] abs1, abs2;
  logic            dz, ovf, fast, cap, start;
  logic [XLEN-1:0] fast_val;

  logic [XLEN:0]   as_a, as_b, as_y;
  logic            as_sub, as_co;
  logic [XLEN-1:0] hi_n, lo_n;

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quot_s, rem_s, res;

  assign op_e  = mdu_op_e'(op);
  assign start = op_start && op_wait_handle;

  assign s1 = (op_e == MDU_MULH) || (op_e == MDU_MULHSU) ||
              (op_e == MDU_DIV)  || (op_e == MDU_REM);
  assign s2 = (op_e == MDU_MULH) ||
              (op_e == MDU_DIV)  || (op_e == MDU_REM);

  assign neg1 = s1 && in1[XLEN-1];
  assign neg2 = s2 && in2[XLEN-1];
  assign abs1 = neg1 ? -in1 : in1;
  assign abs2 = neg2 ? -in2 : in2;

  assign dz   = (in2 == '0);
  assign ovf  = ((op_e == MDU_DIV) || (op_e == MDU_REM)) &&
                (in1 == MDU_OVF_Q) && (&in2);
  assign fast = op_e[2] && (dz || ovf);

  always_comb begin
    fast_val = '0;
    unique case (1'b1)
      dz && !op_e[1]:  fast_val = MDU_DIV0_Q;
      dz && op_e[1]:   fast_val = in1;
      ovf && !op_e[1]: fast_val = MDU_OVF_Q;
      default:         fast_val = '0;
    endcase
  end

  // Multiply gates the multiplicand by the multiplier LSB;
  // divide trial-subtracts the divisor from the shifted remainder.
  assign as_sub = op_q[2];
  assign as_a   = op_q[2] ? {hi, lo[XLEN-1]} : {1'b0, hi};
  assign as_b   = op_q[2] ? {1'b0, bq} :
                  {1'b0, bq & {XLEN{lo[0]}}};

  core_ex_mdu_addsub #(.W(XLEN+1)) u_addsub (
    .a   (as_a),
    .b   (as_b),
    .sub (as_sub),
    .y   (as_y),
    .co  (as_co)
  );

  always_comb begin
    hi_n = as_y[XLEN:1];
    lo_n = {as_y[0], lo[XLEN-1:1]};
    if (op_q[2]) begin
      hi_n = as_co ? as_y[XLEN-1:0] : as_a[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], as_co};
    end
  end

  assign prod_s = neg_q  ? -{hi, lo} : {hi, lo};
  assign quot_s = neg_q  ? -lo : lo;
  assign rem_s  = negr_q ? -hi : hi;

  always_comb begin
    res = '0;
    unique case (op_q)
      MDU_MUL:                         res = prod_s[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: res = prod_s[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               res = quot_s;
      MDU_REM, MDU_REMU:               res = rem_s;
      default:                         res = '0;
    endcase
  end

  always_comb begin
    state_d = state;
    cap     = 1'b0;
    unique case (state)
      MDU_IDLE: cap = op_wait_handle;
      MDU_CALC: begin
        if (start) cap = 1'b1;
        else if (cnt == CNT_W'(XLEN-1)) state_d = MDU_FIX;
      end
      MDU_FIX: begin
        if (start) cap = 1'b1;
        else state_d = MDU_DONE;
      end
      MDU_DONE: begin
        if (start) cap = 1'b1;
        else if (!op_wait_handle) state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
    if (cap) state_d = fast ? MDU_DONE : MDU_CALC;
    if (flush) begin
      state_d = MDU_IDLE;
      cap     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state  <= MDU_IDLE;
      cnt    <= '0;
      op_q   <= MDU_MUL;
      hi     <= '0;
      lo     <= '0;
      bq     <= '0;
      neg_q  <= 1'b0;
      negr_q <= 1'b0;
      out    <= '0;
    end else begin
      state <= state_d;
      if (flush) begin
        cnt <= '0;
      end else if (cap) begin
        cnt    <= '0;
        op_q   <= op_e;
        hi     <= '0;
        lo     <= abs1;
        bq     <= abs2;
        neg_q  <= neg1 ^ neg2;
        negr_q <= neg1;
        if (fast) out <= fast_val;
      end else if (state == MDU_CALC) begin
        cnt <= cnt + 1'b1;
        hi  <= hi_n;
        lo  <= lo_n;
      end else if (state == MDU_FIX) begin
        out <= res;
      end
    end
  end

  assign op_ready = (state == MDU_DONE) ||
                    (state == MDU_IDLE && !op_wait_handle);
  assign busy     = (state == MDU_CALC) || (state == MDU_FIX);

endmodule

// File: tb/tb_core_ex_mdu.sv
// Directed bench for core_ex_mdu.
// Checks results, latency, flush, back-to-back and async reset.
module tb_core_ex_mdu;

  logic        clk = 1'b0;
  logic        rest = 1'b0;
  logic        op_wait_handle = 1'b0;
  logic        op_start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        flush = 1'b0;
  logic        op_ready;
  logic [31:0] out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  core_ex_mdu dut (
    .clk            (clk),
    .rest           (rest),
    .op_wait_handle (op_wait_handle),
    .op_start       (op_start),
    .op             (op),
    .in1            (in1),
    .in2            (in2),
    .flush          (flush),
    .op_ready       (op_ready),
    .out            (out),
    .busy           (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    op_wait_handle = 1'b1;
    op_start       = 1'b1;
    op  = o;
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
    op_start = 1'b0;
  endtask

  task automatic run_op(input string tag,
                        input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int exp_lat);
    int lat;
    issue(o, a, b);
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_lat > 1});
    lat = 1;
    while (!op_ready && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_out"}, out, exp);
  endtask

  task automatic go_idle();
    @(negedge clk);
    op_wait_handle = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_ready", {31'd0, op_ready}, 32'd1);
  endtask

  initial begin
    #2;
    chk("rst_ready", {31'd0, op_ready}, 32'd1);
    chk("rst_out", out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rest = 1'b1;

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    go_idle();
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 34);
    go_idle();
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
    go_idle();
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 34);
    go_idle();
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    go_idle();
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    go_idle();
    run_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 34);
    go_idle();
    run_op("divu0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    go_idle();
    run_op("rem0", 3'd6, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
    go_idle();
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1);
    go_idle();
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    go_idle();

    issue(3'd4, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    op_start = 1'b1;
    op_wait_handle = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    op_start = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_ready", {31'd0, op_ready}, 32'd1);
    chk("flush_out", out, 32'd0);
    run_op("mul35", 3'd0, 32'd3, 32'd5, 32'd15, 34);

    run_op("b2b", 3'd0, 32'd9, 32'd11, 32'd99, 34);
    run_op("b2bdiv", 3'd5, 32'd99, 32'd9, 32'd11, 34);

    issue(3'd4, 32'd50, 32'd5);
    repeat (5) @(posedge clk);
    #2;
    rest = 1'b0;
    op_wait_handle = 1'b0;
    #1;
    chk("arst_ready", {31'd0, op_ready}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_out", out, 32'd0);
    @(negedge clk);
    rest = 1'b1;
    run_op("post_rst", 3'd0, 32'd4, 32'd6, 32'd24, 34);
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
